fir_stream_checker: RTL and testbench

- Synthesizable AXI-stream sink for the FIR output side.
- Captures a no-backpressure filter output stream (tvalid/tdata only) into a FIFO.
- Pairs each captured sample with an expected sample from a reference AXI-stream and emits the signed difference.
- Keeps on-chip statistics: sample count, errors, max abs error, first error index, inter-sample clock delta, overflow.

---
 rtl/fir_stream_checker.sv | 150 +++++++++++++++
 tb/tb_fir_stream_checker.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_checker.sv
// Stream checker for the FIR output: buffers filter samples in a FIFO, pairs each with a
// reference sample, emits the signed difference and keeps running error statistics.
module fir_stream_checker #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 16,
    parameter int TOL    = 0,
    parameter int CNT_W  = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_axis_dut_tvalid,
    input  logic [DATA_W-1:0]        s_axis_dut_tdata,
    input  logic                     s_axis_ref_tvalid,
    output logic                     s_axis_ref_tready,
    input  logic [DATA_W-1:0]        s_axis_ref_tdata,
    input  logic                     stats_clear,
    output logic                     m_diff_tvalid,
    output logic [DATA_W:0]          m_diff_tdata,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         error_cnt,
    output logic [DATA_W:0]          max_abs_diff,
    output logic [CNT_W-1:0]         first_err_idx,
    output logic                     err_seen,
    output logic [CNT_W-1:0]         last_delta,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_W:0]  L_TOL     = (DATA_W+1)'(TOL);
    localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
    localparam logic [AW:0]      L_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]      L_LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]    L_PTR_ONE = AW'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              r_overflow;
    logic              r_diff_valid;
    logic [DATA_W:0]   r_diff;
    logic [CNT_W-1:0]  r_sample_cnt;
    logic [CNT_W-1:0]  r_error_cnt;
    logic [DATA_W:0]   r_max_abs;
    logic [CNT_W-1:0]  r_first_idx;
    logic              r_err_seen;
    logic [CNT_W-1:0]  r_gap;
    logic [CNT_W-1:0]  r_last_delta;

    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [DATA_W-1:0]        w_head;
    logic signed [DATA_W:0]   w_diff;
    logic [DATA_W:0]          w_absd;
    logic                     w_err;
    logic [CNT_W-1:0]         w_gap_inc;

    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign w_full = (r_level == L_DEPTH);
    assign w_pop  = s_axis_ref_tvalid && (r_level != '0);
    assign w_push = s_axis_dut_tvalid && (!w_full || w_pop);
    assign w_drop = s_axis_dut_tvalid && w_full && !w_pop;
    assign w_head = r_mem[r_rd_ptr];

    assign w_diff = $signed({s_axis_ref_tdata[DATA_W-1], s_axis_ref_tdata})
                  - $signed({w_head[DATA_W-1], w_head});
    assign w_absd = w_diff[DATA_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_err  = (w_absd > L_TOL);
    assign w_gap_inc = (r_gap == '1) ? r_gap : r_gap + L_CNT_ONE;

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_dut_tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            if (w_push && !w_pop)      r_level <= r_level + L_LVL_ONE;
            else if (!w_push && w_pop) r_level <= r_level - L_LVL_ONE;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Clear takes precedence over a coinciding compare for the statistics only.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_diff_valid <= 1'b0;
            r_diff       <= '0;
            r_sample_cnt <= '0;
            r_error_cnt  <= '0;
            r_max_abs    <= '0;
            r_first_idx  <= '0;
            r_err_seen   <= 1'b0;
        end else begin
            r_diff_valid <= w_pop;
            if (w_pop) r_diff <= w_diff;
            if (stats_clear) begin
                r_sample_cnt <= '0;
                r_error_cnt  <= '0;
                r_max_abs    <= '0;
                r_first_idx  <= '0;
                r_err_seen   <= 1'b0;
            end else if (w_pop) begin
                if (r_sample_cnt != '1) r_sample_cnt <= r_sample_cnt + L_CNT_ONE;
                if (w_err) begin
                    if (r_error_cnt != '1) r_error_cnt <= r_error_cnt + L_CNT_ONE;
                    if (!r_err_seen) begin
                        r_first_idx <= r_sample_cnt;
                        r_err_seen  <= 1'b1;
                    end
                end
                if (w_absd > r_max_abs) r_max_abs <= w_absd;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset || stats_clear) begin
            r_gap        <= '0;
            r_last_delta <= '0;
        end else if (s_axis_dut_tvalid) begin
            r_last_delta <= w_gap_inc;
            r_gap        <= '0;
        end else begin
            r_gap <= w_gap_inc;
        end
    end

    assign s_axis_ref_tready = (r_level != '0);
    assign m_diff_tvalid     = r_diff_valid;
    assign m_diff_tdata      = r_diff;
    assign sample_cnt        = r_sample_cnt;
    assign error_cnt         = r_error_cnt;
    assign max_abs_diff      = r_max_abs;
    assign first_err_idx     = r_first_idx;
    assign err_seen          = r_err_seen;
    assign last_delta        = r_last_delta;
    assign fifo_level        = r_level;
    assign overflow          = r_overflow;
endmodule

// File: tb/tb_fir_stream_checker.sv
// Bench for fir_stream_checker: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fir_stream_checker;
    localparam int DW   = 48;
    localparam int DEP  = 16;
    localparam int TOLB = 2;
    localparam int CW   = 32;
    localparam int LW   = $clog2(DEP) + 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_axis_dut_tvalid;
    logic [DW-1:0] s_axis_dut_tdata;
    logic          s_axis_ref_tvalid;
    logic          s_axis_ref_tready;
    logic [DW-1:0] s_axis_ref_tdata;
    logic          stats_clear;
    logic          m_diff_tvalid;
    logic [DW:0]   m_diff_tdata;
    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] error_cnt;
    logic [DW:0]   max_abs_diff;
    logic [CW-1:0] first_err_idx;
    logic          err_seen;
    logic [CW-1:0] last_delta;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    fir_stream_checker #(.DATA_W(DW), .DEPTH(DEP), .TOL(TOLB), .CNT_W(CW)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_dut_tvalid(s_axis_dut_tvalid), .s_axis_dut_tdata(s_axis_dut_tdata),
        .s_axis_ref_tvalid(s_axis_ref_tvalid), .s_axis_ref_tready(s_axis_ref_tready),
        .s_axis_ref_tdata(s_axis_ref_tdata), .stats_clear(stats_clear),
        .m_diff_tvalid(m_diff_tvalid), .m_diff_tdata(m_diff_tdata),
        .sample_cnt(sample_cnt), .error_cnt(error_cnt), .max_abs_diff(max_abs_diff),
        .first_err_idx(first_err_idx), .err_seen(err_seen), .last_delta(last_delta),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: queue of captured samples plus plain-arithmetic statistics.
    longint mq[$];
    bit     m_started = 0;
    bit     e_dv = 0;
    longint e_diff = 0;
    longint e_sc = 0, e_ec = 0, e_max = 0, e_fidx = 0, e_gap = 0, e_ld = 0;
    bit     e_seen = 0, e_ovf = 0;

    always @(posedge aclk) begin : model
        longint d, rf, df, ad;
        bit pop;
        m_started = 1;
        if (areset) begin
            mq.delete();
            e_dv = 0; e_diff = 0;
            e_sc = 0; e_ec = 0; e_max = 0; e_fidx = 0; e_seen = 0;
            e_gap = 0; e_ld = 0; e_ovf = 0;
        end else begin
            pop = s_axis_ref_tvalid && (mq.size() != 0);
            e_dv = pop;
            if (pop) begin
                d  = mq.pop_front();
                rf = longint'($signed(s_axis_ref_tdata));
                df = rf - d;
                e_diff = df;
                ad = (df < 0) ? -df : df;
                if (!stats_clear) begin
                    if (ad > TOLB) begin
                        if (!e_seen) begin
                            e_fidx = e_sc;
                            e_seen = 1;
                        end
                        e_ec++;
                    end
                    e_sc++;
                    if (ad > e_max) e_max = ad;
                end
            end
            if (s_axis_dut_tvalid) begin
                if (mq.size() < DEP) mq.push_back(longint'($signed(s_axis_dut_tdata)));
                else e_ovf = 1;
            end
            if (stats_clear) begin
                e_sc = 0; e_ec = 0; e_max = 0; e_fidx = 0; e_seen = 0;
                e_gap = 0; e_ld = 0;
            end else if (s_axis_dut_tvalid) begin
                e_ld = e_gap + 1;
                e_gap = 0;
            end else begin
                e_gap++;
            end
        end
    end

    int     n_pulse = 0;
    longint dut_last_diff = 0;

    always @(negedge aclk) begin
        if (m_started) begin
            chk("diff_valid", m_diff_tvalid, e_dv);
            if (e_dv) chk("diff_data", longint'($signed(m_diff_tdata)), e_diff);
            chk("sample_cnt", sample_cnt, e_sc);
            chk("error_cnt", error_cnt, e_ec);
            chk("max_abs_diff", max_abs_diff, e_max);
            chk("first_err_idx", first_err_idx, e_fidx);
            chk("err_seen", err_seen, e_seen);
            chk("last_delta", last_delta, e_ld);
            chk("fifo_level", fifo_level, mq.size());
            chk("overflow", overflow, e_ovf);
            chk("ref_tready", s_axis_ref_tready, mq.size() != 0);
            if (m_diff_tvalid) begin
                n_pulse++;
                dut_last_diff = longint'($signed(m_diff_tdata));
            end
        end
    end

    longint dvec[$];
    longint rvec[$];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        s_axis_dut_tvalid = 0;
        s_axis_ref_tvalid = 0;
        stats_clear = 0;
    endtask

    task automatic run(input int ref_start, input int period, input bit ref_en);
        int di = 0;
        int ri = 0;
        int c = 0;
        bit hs, dv;
        longint t;
        while ((di < dvec.size() || (ref_en && ri < rvec.size())) && c < 300) begin
            dv = (di < dvec.size()) && (c % period == 0);
            s_axis_dut_tvalid = dv;
            if (di < dvec.size()) begin
                t = dvec[di];
                s_axis_dut_tdata = t[DW-1:0];
            end
            s_axis_ref_tvalid = ref_en && (c >= ref_start) && (ri < rvec.size());
            if (ri < rvec.size()) begin
                t = rvec[ri];
                s_axis_ref_tdata = t[DW-1:0];
            end
            hs = s_axis_ref_tvalid && s_axis_ref_tready;
            tick();
            if (dv) di++;
            if (hs) ri++;
            c++;
        end
        idle();
        if (c >= 300) begin
            total++;
            bad++;
            $display("FAIL run_timeout actual=%0d expected=<300", c);
        end
        tick();
        tick();
    endtask

    localparam longint P47 = longint'(1) << 47;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1;
        stats_clear = 0;
        s_axis_dut_tvalid = 1; s_axis_dut_tdata = 48'd9;
        s_axis_ref_tvalid = 1; s_axis_ref_tdata = 48'd9;
        repeat (5) tick();
        chk("rst_level", fifo_level, 0);
        chk("rst_tready", s_axis_ref_tready, 0);
        chk("rst_dv", m_diff_tvalid, 0);
        chk("rst_sc", sample_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ld", last_delta, 0);
        areset = 0;
        idle();
        tick();
        chk("rst_nopush", fifo_level, 0);

        // match: dut 1..8, ref 1..8 starting 3 cycles later
        dvec.delete(); rvec.delete();
        for (int i = 1; i <= 8; i++) begin dvec.push_back(i); rvec.push_back(i); end
        n_pulse = 0;
        run(3, 1, 1);
        chk("match_pulses", n_pulse, 8);
        chk("match_sc", sample_cnt, 8);
        chk("match_ec", error_cnt, 0);
        chk("match_max", max_abs_diff, 0);
        chk("match_ld", last_delta, 1);
        chk("match_level", fifo_level, 0);

        // tolerance
        stats_clear = 1; tick(); stats_clear = 0;
        dvec = {103}; rvec = {100};
        run(0, 1, 1);
        chk("tol_diff1", dut_last_diff, -3);
        chk("tol_ec1", error_cnt, 1);
        chk("tol_fidx", first_err_idx, 0);
        chk("tol_seen", err_seen, 1);
        dvec = {98}; rvec = {100};
        run(0, 1, 1);
        chk("tol_diff2", dut_last_diff, 2);
        chk("tol_ec2", error_cnt, 1);
        chk("tol_max", max_abs_diff, 3);
        chk("tol_sc", sample_cnt, 2);

        // extremes
        dvec = {-P47}; rvec = {P47 - 1};
        run(0, 1, 1);
        chk("ext_diff_pos", dut_last_diff, (longint'(1) << 48) - 1);
        chk("ext_max", max_abs_diff, (longint'(1) << 48) - 1);
        dvec = {P47 - 1}; rvec = {-P47};
        run(0, 1, 1);
        chk("ext_diff_neg", dut_last_diff, -((longint'(1) << 48) - 1));

        // overflow: 17 samples with no reference, then full-with-pop
        stats_clear = 1; tick(); stats_clear = 0;
        dvec.delete(); rvec.delete();
        for (int i = 1; i <= 17; i++) dvec.push_back(10 * i);
        run(0, 1, 0);
        chk("ovf_level", fifo_level, 16);
        chk("ovf_flag", overflow, 1);
        for (int k = 0; k < 3; k++) begin
            s_axis_dut_tvalid = 1; s_axis_dut_tdata = 48'(1000 + k);
            s_axis_ref_tvalid = 1; s_axis_ref_tdata = 48'(10 * (k + 1));
            tick();
            chk("ovf_full_pop_level", fifo_level, 16);
        end
        idle();
        dvec.delete(); rvec.delete();
        for (int i = 4; i <= 16; i++) rvec.push_back(10 * i);
        for (int k = 0; k < 3; k++) rvec.push_back(1000 + k);
        run(0, 1, 1);
        chk("ovf_sc", sample_cnt, 19);
        chk("ovf_ec", error_cnt, 0);
        chk("ovf_max", max_abs_diff, 0);
        chk("ovf_drain", fifo_level, 0);

        // gap: dut every 4th cycle
        dvec = {5, 6, 7}; rvec = {5, 6, 9};
        run(0, 4, 1);
        chk("gap_ld", last_delta, 4);
        chk("gap_diff", dut_last_diff, 2);

        // clear coinciding with a compare
        s_axis_dut_tvalid = 1; s_axis_dut_tdata = 48'd5;
        tick();
        idle();
        tick();
        s_axis_ref_tvalid = 1; s_axis_ref_tdata = 48'd7; stats_clear = 1;
        tick();
        idle();
        chk("clr_dv", m_diff_tvalid, 1);
        chk("clr_diff", longint'($signed(m_diff_tdata)), 2);
        chk("clr_sc", sample_cnt, 0);
        tick();

        // reset mid-stream with 5 entries held
        dvec = {1, 2, 3, 4, 5}; rvec.delete();
        run(0, 1, 0);
        chk("mid_level5", fifo_level, 5);
        areset = 1;
        tick();
        chk("mid_level0", fifo_level, 0);
        chk("mid_ovf", overflow, 0);
        chk("mid_tready", s_axis_ref_tready, 0);
        areset = 0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
